// File: rtl/integrate_and_dump_clip.sv
// rtl/integrate_and_dump_clip.sv - programmable integrate-and-dump decimator with rounding and clipping
module integrate_and_dump_clip #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic [CNT_WIDTH-1:0]               decim,
  input  logic [$clog2(CNT_WIDTH+1)-1:0]     shift,
  input  logic signed [WIDTH-1:0]            in,
  input  logic                               strobe_in,
  output logic signed [WIDTH-1:0]            out,
  output logic                               strobe_out
);

  localparam int ACC_WIDTH = WIDTH + CNT_WIDTH;
  localparam int SW        = $clog2(CNT_WIDTH + 1);
  localparam logic [SW-1:0] SHIFT_MAX = SW'(CNT_WIDTH);

  // Clip rails expressed at the widened rounding precision
  localparam logic signed [ACC_WIDTH:0] MAX_V =
    {{(ACC_WIDTH-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_V =
    {{(ACC_WIDTH-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [CNT_WIDTH-1:0]         decim_l;
  logic [SW-1:0]                shift_l;

  logic [SW-1:0]                shift_sat;
  logic [CNT_WIDTH-1:0]         decim_eff;
  logic [SW-1:0]                shift_eff;
  logic                         accept;
  logic                         last;
  logic signed [ACC_WIDTH-1:0]  total;
  logic signed [ACC_WIDTH:0]    rnd_add;
  logic signed [ACC_WIDTH:0]    rnd_sum;
  logic signed [ACC_WIDTH:0]    shifted;
  logic signed [WIDTH-1:0]      clipped;

  // Window parameters: the ports apply at a window start, latched copies otherwise
  always_comb begin
    shift_sat = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    decim_eff = (state == IDLE) ? decim : decim_l;
    shift_eff = (state == IDLE) ? shift_sat : shift_l;
    accept    = strobe_in && !clear;
    last      = (cnt == decim_eff);
  end

  // Running total including this cycle's sample, then round, shift and clip it
  always_comb begin
    total   = acc + {{CNT_WIDTH{in[WIDTH-1]}}, in};
    rnd_add = '0;
    if (shift_eff != '0) begin
      rnd_add = {{ACC_WIDTH{1'b0}}, 1'b1} << (shift_eff - SW'(1));
    end
    // One extra bit so the rounding offset can never wrap the accumulator value
    rnd_sum = {total[ACC_WIDTH-1], total} + rnd_add;
    shifted = rnd_sum >>> shift_eff;
    if (shifted > MAX_V) begin
      clipped = MAX_V[WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      clipped = MIN_V[WIDTH-1:0];
    end else begin
      clipped = shifted[WIDTH-1:0];
    end
  end

  // Window FSM: accumulate accepted samples, dump on the last one, restart on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      decim_l    <= '0;
      shift_l    <= '0;
      out        <= '0;
      strobe_out <= 1'b0;
    end else begin
      strobe_out <= 1'b0;
      if (clear) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else if (accept) begin
        if (state == IDLE) begin
          decim_l <= decim;
          shift_l <= shift_sat;
        end
        if (last) begin
          out        <= clipped;
          strobe_out <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          state      <= IDLE;
        end else begin
          acc   <= total;
          cnt   <= cnt + CNT_WIDTH'(1);
          state <= ACCUM;
        end
      end
    end
  end

endmodule
